vend_controller: RTL and testbench
==================================

VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 Parameter PRICE_A, default 3, price of product A in 50-unit steps (150).
REQ-002 Parameter PRICE_B, default 4, price of product B in 50-unit steps (200).
REQ-003 Parameter CREDIT_MAX, default 10, maximum held credit in 50-unit steps (500); legal range 1..31, and PRICE_A, PRICE_B <= CREDIT_MAX.
REQ-004 Parameter TIMEOUT, default 1000, idle cycles in CREDIT before automatic refund; legal range 2..65535.
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 coin50  input  1  level from the 50-coin sensor; each rising edge is one coin.
REQ-008 coin100  input  1  level from the 100-coin sensor; each rising edge is one coin.
REQ-009 sel_a, sel_b  input  1 each  product select buttons; each rising edge is one request.
REQ-010 cancel  input  1  refund button; each rising edge is one request.
REQ-011 state  output  3  FSM state: IDLE=000, CREDIT=001, VEND=010, CHANGE=011.
REQ-012 credit  output  5  current credit in 50-unit steps.
REQ-013 vend_a, vend_b  output  1 each  one-cycle dispense strobe per product.
REQ-014 change_pulse  output  1  one cycle high per 50-unit coin returned.
REQ-015 coin_reject  output  1  one-cycle strobe: the coin was not accepted and is to be returned mechanically.

Function
REQ-016 Each of the five inputs SHALL pass through a sampling register plus a registered rising-edge detector, giving a one-cycle trig pulse on the edge after the input is first sampled high; FSM action occurs on the following edge, for 2-clock input-to-effect latency.
REQ-017 A level held high SHALL produce exactly one trig; a new trig requires a low sample first.
REQ-018 Coin value: coin50 = 1 unit, coin100 = 2 units; simultaneous coin50 and coin100 trigs SHALL be treated as one 3-unit deposit.
REQ-019 IDLE, coin trig with deposit <= CREDIT_MAX: credit <= deposit, state <= CREDIT.
REQ-020 In IDLE or CREDIT, a deposit that would make credit exceed CREDIT_MAX SHALL be rejected as a whole: credit unchanged, coin_reject pulses one cycle.
REQ-021 Any coin trig in VEND or CHANGE SHALL be rejected with a coin_reject pulse.
REQ-022 CREDIT priority per cycle: cancel > sel_a > sel_b > coin; lower-priority trigs in the same cycle SHALL be discarded, and discarded coins pulse coin_reject.
REQ-023 CREDIT, sel_a trig with credit >= PRICE_A: credit <= credit - PRICE_A, latch product A, state <= VEND; sel_b is analogous with PRICE_B.
REQ-024 A select trig with insufficient credit SHALL be ignored, apart from restarting the timeout counter.
REQ-025 CREDIT, cancel trig: state <= CHANGE with credit unchanged.
REQ-026 Select and cancel trigs in IDLE, VEND and CHANGE SHALL be ignored.
REQ-027 VEND lasts exactly one cycle: vend_a or vend_b (latched product) is high during that cycle only; the next state is IDLE if credit==0, else CHANGE.
REQ-028 CHANGE: change_pulse is high every cycle state==CHANGE, and credit decrements by 1 each cycle; at credit==1, credit <= 0 and state <= IDLE, giving exactly N pulses for N units of credit.
REQ-029 Timeout counter: 16 bits, cleared on entry to CREDIT and on every accepted coin or select trig in CREDIT, incrementing otherwise; on reaching TIMEOUT-1, state <= CHANGE and the counter clears.
REQ-030 vend_a, vend_b, change_pulse and coin_reject SHALL never be high in IDLE, except coin_reject per REQ-020.
REQ-031 Unused state encodings SHALL recover to IDLE with credit <= 0 on the next edge.

Reset
REQ-032 rst low SHALL immediately force: state=IDLE, credit=0, all strobes 0, sampling and trig registers 0, timeout counter 0, latched product cleared.
REQ-033 Reset mid-VEND or mid-CHANGE SHALL abandon the operation with no further strobes; credit is lost.
REQ-034 After rst rises, an input already high SHALL yield a trig, because the sampling registers reset to 0.

Verification
REQ-035 coin100, coin50 edges, then sel_a -> credit 2, then 3, then VEND with vend_a one cycle, then IDLE, credit 0, no change_pulse.
REQ-036 3 x coin100, then sel_b -> credit 6 -> VEND (vend_b) -> CHANGE with 2 change_pulse cycles -> IDLE, credit 0.
REQ-037 Credit 9 plus coin100 -> coin_reject one cycle, credit stays 9; coin50 -> credit 10.
REQ-038 Credit 1 with sel_a -> ignored; no input for TIMEOUT cycles -> CHANGE, 1 change_pulse, IDLE.
REQ-039 Credit 4 with cancel, sel_a and coin50 trig in the same cycle -> CHANGE, coin_reject, 4 change_pulses, no vend strobe.
REQ-040 rst asserted during CHANGE with credit 5 -> outputs zero immediately; coin50 held high through release -> one trig, credit 1.

Source files
------------

// File: rtl/vend_controller_if.sv
// rtl/vend_controller_if.sv - coin/button inputs and status/strobe outputs of the vending controller
interface vend_controller_if;
  logic       i_coin50;
  logic       i_coin100;
  logic       i_sel_a;
  logic       i_sel_b;
  logic       i_cancel;
  logic [2:0] o_state;
  logic [4:0] o_credit;
  logic       o_vend_a;
  logic       o_vend_b;
  logic       o_change_pulse;
  logic       o_coin_reject;

  modport master (
    output i_coin50, i_coin100, i_sel_a, i_sel_b, i_cancel,
    input  o_state, o_credit, o_vend_a, o_vend_b, o_change_pulse, o_coin_reject
  );

  modport slave (
    input  i_coin50, i_coin100, i_sel_a, i_sel_b, i_cancel,
    output o_state, o_credit, o_vend_a, o_vend_b, o_change_pulse, o_coin_reject
  );
endinterface

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - coin-operated two-product vending controller with change return
module vend_controller #(
  parameter int PRICE_A    = 3,
  parameter int PRICE_B    = 4,
  parameter int CREDIT_MAX = 10,
  parameter int TIMEOUT    = 1000
) (
  input  logic              clk,
  input  logic              rst,
  vend_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_CREDIT = 3'b001,
    ST_VEND   = 3'b010,
    ST_CHANGE = 3'b011
  } state_t;

  localparam logic [5:0]  MAX_W    = 6'(CREDIT_MAX);
  localparam logic [4:0]  PA_W     = 5'(PRICE_A);
  localparam logic [4:0]  PB_W     = 5'(PRICE_B);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  // trigger bit order: {cancel, sel_b, sel_a, coin100, coin50}
  logic [4:0]  w_in;
  logic [4:0]  r_samp;
  logic [4:0]  r_trig;
  logic        w_t_c50, w_t_c100, w_t_sel_a, w_t_sel_b, w_t_cancel;
  logic        w_coin;
  logic [1:0]  w_dep;
  logic [5:0]  w_sum;
  logic        w_fits;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_credit, w_credit_nxt;
  logic [15:0] r_tmo, w_tmo_nxt;
  logic        r_prod_b, w_prod_b_nxt;
  logic        w_reject;

  assign w_in = {bus.i_cancel, bus.i_sel_b, bus.i_sel_a, bus.i_coin100, bus.i_coin50};

  assign w_t_c50    = r_trig[0];
  assign w_t_c100   = r_trig[1];
  assign w_t_sel_a  = r_trig[2];
  assign w_t_sel_b  = r_trig[3];
  assign w_t_cancel = r_trig[4];

  // simultaneous coins form one 3-unit deposit: value is simply {c100, c50}
  assign w_coin = w_t_c50 | w_t_c100;
  assign w_dep  = {w_t_c100, w_t_c50};
  assign w_sum  = {1'b0, r_credit} + {4'b0, w_dep};
  assign w_fits = (w_sum <= MAX_W);

  // sample inputs and flag the first high sample as a one-cycle trigger
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_samp <= '0;
      r_trig <= '0;
    end else begin
      r_samp <= w_in;
      r_trig <= w_in & ~r_samp;
    end
  end

  // state, credit, timeout counter and latched product
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_credit <= '0;
      r_tmo    <= '0;
      r_prod_b <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_credit <= w_credit_nxt;
      r_tmo    <= w_tmo_nxt;
      r_prod_b <= w_prod_b_nxt;
    end
  end

  // next-state decisions; a coin that is not accepted this cycle is rejected
  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_tmo_nxt    = r_tmo;
    w_prod_b_nxt = r_prod_b;
    w_reject     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_coin) begin
          if (w_fits) begin
            w_credit_nxt = w_sum[4:0];
            w_state_nxt  = ST_CREDIT;
            w_tmo_nxt    = '0;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      ST_CREDIT: begin
        if (w_t_cancel) begin
          w_reject    = w_coin;
          w_state_nxt = ST_CHANGE;
          w_tmo_nxt   = '0;
        end else if (w_t_sel_a) begin
          w_reject  = w_coin;
          w_tmo_nxt = '0;
          if (r_credit >= PA_W) begin
            w_credit_nxt = r_credit - PA_W;
            w_prod_b_nxt = 1'b0;
            w_state_nxt  = ST_VEND;
          end
        end else if (w_t_sel_b) begin
          w_reject  = w_coin;
          w_tmo_nxt = '0;
          if (r_credit >= PB_W) begin
            w_credit_nxt = r_credit - PB_W;
            w_prod_b_nxt = 1'b1;
            w_state_nxt  = ST_VEND;
          end
        end else if (w_coin && w_fits) begin
          w_credit_nxt = w_sum[4:0];
          w_tmo_nxt    = '0;
        end else begin
          w_reject = w_coin;
          if (r_tmo == TMO_LAST) begin
            w_state_nxt = ST_CHANGE;
            w_tmo_nxt   = '0;
          end else begin
            w_tmo_nxt = r_tmo + 16'd1;
          end
        end
      end
      ST_VEND: begin
        w_reject    = w_coin;
        w_state_nxt = (r_credit == 5'd0) ? ST_IDLE : ST_CHANGE;
      end
      ST_CHANGE: begin
        w_reject = w_coin;
        if (r_credit <= 5'd1) begin
          w_credit_nxt = '0;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_credit_nxt = r_credit - 5'd1;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_credit_nxt = '0;
        w_tmo_nxt    = '0;
      end
    endcase
  end

  assign bus.o_state        = r_state;
  assign bus.o_credit       = r_credit;
  assign bus.o_vend_a       = (r_state == ST_VEND) && !r_prod_b;
  assign bus.o_vend_b       = (r_state == ST_VEND) && r_prod_b;
  assign bus.o_change_pulse = (r_state == ST_CHANGE);
  assign bus.o_coin_reject  = w_reject;

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - vector table, corner sequences and random run against a reference model
module tb_vend_controller;
  localparam int PA   = 3;
  localparam int PB   = 4;
  localparam int CMAX = 10;
  localparam int TMO  = 20;

  localparam int S_IDLE = 0, S_CREDIT = 1, S_VEND = 2, S_CHANGE = 3;

  localparam bit [4:0] C50 = 5'b00001;
  localparam bit [4:0] C100 = 5'b00010;
  localparam bit [4:0] SA = 5'b00100;
  localparam bit [4:0] SB = 5'b01000;
  localparam bit [4:0] CN = 5'b10000;
  localparam bit [4:0] NONE = 5'b00000;

  logic clk = 1'b0;
  logic rst = 1'b0;

  vend_controller_if bus();

  vend_controller #(
    .PRICE_A(PA), .PRICE_B(PB), .CREDIT_MAX(CMAX), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // reference model: plain integers, edge detection by previous level, 1-cycle trigger delay
  int       m_state, m_credit, m_idle;
  bit       m_prod_b;
  bit [4:0] m_prev, m_trig;

  typedef struct {
    bit [4:0]  in;
    bit [11:0] exp;
  } vec_t;

  vec_t tbl[32];

  function automatic bit [11:0] pack(int st, int cr, bit va, bit vb, bit chg, bit rej);
    return {3'(st), 5'(cr), va, vb, chg, rej};
  endfunction

  function automatic vec_t mk(bit [4:0] in, int st, int cr, bit va, bit vb, bit chg, bit rej);
    vec_t v;
    v.in  = in;
    v.exp = pack(st, cr, va, vb, chg, rej);
    return v;
  endfunction

  function automatic logic [11:0] dut_out();
    return {bus.o_state, bus.o_credit, bus.o_vend_a, bus.o_vend_b,
            bus.o_change_pulse, bus.o_coin_reject};
  endfunction

  function automatic bit model_reject();
    int dep;
    bit coin;
    coin = m_trig[0] | m_trig[1];
    dep  = (m_trig[0] ? 1 : 0) + (m_trig[1] ? 2 : 0);
    if (!coin) return 1'b0;
    if (m_state == S_IDLE) return (dep > CMAX);
    if (m_state == S_CREDIT) return (m_trig[4] | m_trig[3] | m_trig[2]) || (m_credit + dep > CMAX);
    return 1'b1;
  endfunction

  function automatic bit [11:0] model_out();
    return pack(m_state, m_credit,
                m_state == S_VEND && !m_prod_b, m_state == S_VEND && m_prod_b,
                m_state == S_CHANGE, model_reject());
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_credit = 0; m_idle = 0; m_prod_b = 0;
    m_prev = '0; m_trig = '0;
  endtask

  task automatic model_step(input bit [4:0] in);
    int dep;
    bit coin;
    coin = m_trig[0] | m_trig[1];
    dep  = (m_trig[0] ? 1 : 0) + (m_trig[1] ? 2 : 0);
    case (m_state)
      S_IDLE:
        if (coin && dep <= CMAX) begin
          m_credit = dep; m_state = S_CREDIT; m_idle = 0;
        end
      S_CREDIT:
        if (m_trig[4]) m_state = S_CHANGE;
        else if (m_trig[2]) begin
          m_idle = 0;
          if (m_credit >= PA) begin m_credit -= PA; m_prod_b = 0; m_state = S_VEND; end
        end else if (m_trig[3]) begin
          m_idle = 0;
          if (m_credit >= PB) begin m_credit -= PB; m_prod_b = 1; m_state = S_VEND; end
        end else if (coin && m_credit + dep <= CMAX) begin
          m_credit += dep; m_idle = 0;
        end else if (m_idle == TMO - 1) begin
          m_state = S_CHANGE; m_idle = 0;
        end else m_idle++;
      S_VEND: m_state = (m_credit == 0) ? S_IDLE : S_CHANGE;
      default:
        if (m_credit <= 1) begin m_credit = 0; m_state = S_IDLE; end
        else m_credit--;
    endcase
    m_trig = in & ~m_prev;
    m_prev = in;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input bit [4:0] in);
    bus.i_coin50  = in[0];
    bus.i_coin100 = in[1];
    bus.i_sel_a   = in[2];
    bus.i_sel_b   = in[3];
    bus.i_cancel  = in[4];
  endtask

  task automatic step(input bit [4:0] in);
    set_in(in);
    @(posedge clk);
    #1;
    model_step(in);
    check("model", 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic step_exp(input string name, input bit [4:0] in, input bit [11:0] exp);
    step(in);
    check(name, 32'(dut_out()), 32'(exp));
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    set_in(NONE);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #4 rst = 1'b1;
  endtask

  initial begin
    int k, n_chg, n_vend;
    bit [4:0] lv;
    set_in(NONE);
    model_reset();
    @(posedge clk);
    #4 rst = 1'b1;
    #1 check("reset_state", 32'(dut_out()), 32'(pack(S_IDLE, 0, 0, 0, 0, 0)));

    tbl[0]  = mk(C100,     S_IDLE,   0, 0, 0, 0, 0);
    tbl[1]  = mk(NONE,     S_CREDIT, 2, 0, 0, 0, 0);
    tbl[2]  = mk(C50,      S_CREDIT, 2, 0, 0, 0, 0);
    tbl[3]  = mk(NONE,     S_CREDIT, 3, 0, 0, 0, 0);
    tbl[4]  = mk(SA,       S_CREDIT, 3, 0, 0, 0, 0);
    tbl[5]  = mk(NONE,     S_VEND,   0, 1, 0, 0, 0);
    tbl[6]  = mk(NONE,     S_IDLE,   0, 0, 0, 0, 0);
    tbl[7]  = mk(NONE,     S_IDLE,   0, 0, 0, 0, 0);
    tbl[8]  = mk(C100,     S_IDLE,   0, 0, 0, 0, 0);
    tbl[9]  = mk(NONE,     S_CREDIT, 2, 0, 0, 0, 0);
    tbl[10] = mk(C100,     S_CREDIT, 2, 0, 0, 0, 0);
    tbl[11] = mk(NONE,     S_CREDIT, 4, 0, 0, 0, 0);
    tbl[12] = mk(C100,     S_CREDIT, 4, 0, 0, 0, 0);
    tbl[13] = mk(NONE,     S_CREDIT, 6, 0, 0, 0, 0);
    tbl[14] = mk(SB,       S_CREDIT, 6, 0, 0, 0, 0);
    tbl[15] = mk(NONE,     S_VEND,   2, 0, 1, 0, 0);
    tbl[16] = mk(NONE,     S_CHANGE, 2, 0, 0, 1, 0);
    tbl[17] = mk(NONE,     S_CHANGE, 1, 0, 0, 1, 0);
    tbl[18] = mk(NONE,     S_IDLE,   0, 0, 0, 0, 0);
    tbl[19] = mk(NONE,     S_IDLE,   0, 0, 0, 0, 0);
    tbl[20] = mk(C50|C100, S_IDLE,   0, 0, 0, 0, 0);
    tbl[21] = mk(NONE,     S_CREDIT, 3, 0, 0, 0, 0);
    tbl[22] = mk(C50|C100, S_CREDIT, 3, 0, 0, 0, 0);
    tbl[23] = mk(NONE,     S_CREDIT, 6, 0, 0, 0, 0);
    tbl[24] = mk(C50|C100, S_CREDIT, 6, 0, 0, 0, 0);
    tbl[25] = mk(NONE,     S_CREDIT, 9, 0, 0, 0, 0);
    tbl[26] = mk(C100,     S_CREDIT, 9, 0, 0, 0, 1);
    tbl[27] = mk(NONE,     S_CREDIT, 9, 0, 0, 0, 0);
    tbl[28] = mk(C50,      S_CREDIT, 9, 0, 0, 0, 0);
    tbl[29] = mk(NONE,     S_CREDIT, 10, 0, 0, 0, 0);
    tbl[30] = mk(CN,       S_CREDIT, 10, 0, 0, 0, 0);
    tbl[31] = mk(NONE,     S_CHANGE, 10, 0, 0, 1, 0);

    for (int i = 0; i < 32; i++) begin
      step(tbl[i].in);
      if (dut_out() !== tbl[i].exp) $display("FAIL tbl[%0d]: got %h expected %h", i, dut_out(), tbl[i].exp);
      n_vec++;
      if (dut_out() !== tbl[i].exp) n_bad++;
    end

    // underfunded select is ignored, then the idle timeout refunds the single unit
    do_reset();
    step(C50);
    step_exp("credit1", NONE, pack(S_CREDIT, 1, 0, 0, 0, 0));
    step(SA);
    step_exp("sel_a_ignored", NONE, pack(S_CREDIT, 1, 0, 0, 0, 0));
    k = 0;
    while (bus.o_state != 3'(S_CHANGE) && k < TMO + 5) begin
      step(NONE);
      k++;
    end
    check("timeout_cycles", 32'(k), 32'(TMO));
    check("timeout_change", 32'(dut_out()), 32'(pack(S_CHANGE, 1, 0, 0, 1, 0)));
    step_exp("timeout_idle", NONE, pack(S_IDLE, 0, 0, 0, 0, 0));

    // cancel beats select and coin arriving in the same cycle
    step(C100); step(NONE); step(C100);
    step_exp("credit4", NONE, pack(S_CREDIT, 4, 0, 0, 0, 0));
    step_exp("combo_reject", CN | SA | C50, pack(S_CREDIT, 4, 0, 0, 0, 1));
    step_exp("combo_change", NONE, pack(S_CHANGE, 4, 0, 0, 1, 0));
    n_chg = 1; n_vend = 0;
    for (int i = 0; i < 8; i++) begin
      step(NONE);
      n_chg  += bus.o_change_pulse;
      n_vend += bus.o_vend_a + bus.o_vend_b;
    end
    check("combo_pulses", 32'(n_chg), 32'd4);
    check("combo_no_vend", 32'(n_vend), 32'd0);
    check("combo_idle", 32'(dut_out()), 32'(pack(S_IDLE, 0, 0, 0, 0, 0)));

    // reset in the middle of change, with coin50 held high across the release
    step(C100); step(NONE); step(C100); step(NONE); step(C50); step(NONE);
    step_exp("credit5", CN, pack(S_CREDIT, 5, 0, 0, 0, 0));
    step_exp("change5", NONE, pack(S_CHANGE, 5, 0, 0, 1, 0));
    bus.i_coin50 = 1'b1;
    #2 rst = 1'b0;
    #1 check("reset_immediate", 32'(dut_out()), 32'd0);
    model_reset();
    @(posedge clk);
    #1 check("reset_held", 32'(dut_out()), 32'd0);
    #3 rst = 1'b1;
    step_exp("held_trig", C50, pack(S_IDLE, 0, 0, 0, 0, 0));
    step_exp("held_credit", C50, pack(S_CREDIT, 1, 0, 0, 0, 0));
    step_exp("held_once", C50, pack(S_CREDIT, 1, 0, 0, 0, 0));

    // random traffic with periodic quiet stretches so timeouts also occur
    do_reset();
    lv = '0;
    for (int i = 0; i < 3000; i++) begin
      if ((i % 200) >= 165) lv = '0;
      else begin
        lv[0] = ($urandom_range(0, 99) < 25);
        lv[1] = ($urandom_range(0, 99) < 20);
        lv[2] = ($urandom_range(0, 99) < 10);
        lv[3] = ($urandom_range(0, 99) < 10);
        lv[4] = ($urandom_range(0, 99) < 4);
      end
      step(lv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
